// File: rtl/pe_dc_pkg.sv
// pe_dc_pkg: shared state encoding, latency counter width and width helper for pe_dc_sched
package pe_dc_pkg;
    localparam int LAT_W = 3;
    typedef enum logic [2:0] {IDLE, LOAD_W, WAIT_W, REQ_WIN, WAIT_WIN, EXEC, EMIT, FIN} pe_dc_state_t;
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pe_dc_loop_cnt.sv
// pe_dc_loop_cnt: nested position counter, column innermost, then row, then kernel
module pe_dc_loop_cnt
    import pe_dc_pkg::*;
#(
    parameter int OW = 4,
    parameter int OH = 4,
    parameter int N_KERNEL = 8,
    parameter int CW = clog2_min1(OW),
    parameter int RW = clog2_min1(OH),
    parameter int KW = clog2_min1(N_KERNEL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] c,
    output logic [RW-1:0] r,
    output logic [KW-1:0] k,
    output logic          wrap_c,
    output logic          wrap_r,
    output logic          last
);
    logic [CW-1:0] c_q, c_d;
    logic [RW-1:0] r_q, r_d;
    logic [KW-1:0] k_q, k_d;
    always_comb begin
        wrap_c = c_q == CW'(OW - 1);
        wrap_r = r_q == RW'(OH - 1);
        last = wrap_c && wrap_r && (k_q == KW'(N_KERNEL - 1));
        c_d = clr ? '0 : !inc ? c_q : wrap_c ? '0 : c_q + 1'b1;
        r_d = clr ? '0 : !(inc && wrap_c) ? r_q : wrap_r ? '0 : r_q + 1'b1;
        k_d = clr ? '0 : !(inc && wrap_c && wrap_r) ? k_q : last ? '0 : k_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= '0;
            r_q <= '0;
            k_q <= '0;
        end else begin
            c_q <= c_d;
            r_q <= r_d;
            k_q <= k_d;
        end
    end
    assign c = c_q;
    assign r = r_q;
    assign k = k_q;
endmodule

// File: rtl/pe_dc_sched.sv
// pe_dc_sched: per-kernel weight load and per-position window/PE/emit sequencer for one binary-conv PE
module pe_dc_sched
    import pe_dc_pkg::*;
#(
    parameter int OH = 4,
    parameter int OW = 4,
    parameter int N_KERNEL = 8,
    parameter int POOL_H = 2,
    parameter int POOL_W = 2,
    parameter int PE_LAT = 1,
    localparam int OUT_WIDTH = POOL_H * POOL_W,
    localparam int PINDEX_WIDTH = clog2_min1(POOL_H * POOL_W),
    localparam int RW = clog2_min1(OH),
    localparam int CW = clog2_min1(OW),
    localparam int KW = clog2_min1(N_KERNEL)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    wgt_req,
    output logic [KW-1:0]           wgt_k,
    input  logic                    wgt_valid,
    output logic                    win_req,
    output logic [RW-1:0]           win_row,
    output logic [CW-1:0]           win_col,
    input  logic                    win_valid,
    input  logic [PINDEX_WIDTH-1:0] win_pindex,
    output logic [PINDEX_WIDTH-1:0] pe_pindex,
    output logic                    pe_en,
    input  logic [OUT_WIDTH-1:0]    pe_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [KW-1:0]           out_k,
    output logic [RW-1:0]           out_row,
    output logic [CW-1:0]           out_col
);
    pe_dc_state_t state_q, state_d;
    logic busy_q, busy_d;
    logic [PINDEX_WIDTH-1:0] pe_pindex_q, pe_pindex_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [KW-1:0] out_k_q, out_k_d, k;
    logic [RW-1:0] out_row_q, out_row_d, r;
    logic [CW-1:0] out_col_q, out_col_d, c;
    logic cnt_clr, cnt_inc, wrap_c, wrap_r, last;

    pe_dc_loop_cnt #(
        .OW(OW), .OH(OH), .N_KERNEL(N_KERNEL), .CW(CW), .RW(RW), .KW(KW)
    ) u_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_inc),
        .c(c), .r(r), .k(k), .wrap_c(wrap_c), .wrap_r(wrap_r), .last(last)
    );

    always_comb begin
        state_d = state_q;
        busy_d = busy_q;
        pe_pindex_d = pe_pindex_q;
        lat_d = lat_q;
        out_data_d = out_data_q;
        out_k_d = out_k_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD_W;
                busy_d = 1'b1;
                cnt_clr = 1'b1;
            end
            LOAD_W: state_d = WAIT_W;
            WAIT_W: state_d = wgt_valid ? REQ_WIN : WAIT_W;
            REQ_WIN: state_d = WAIT_WIN;
            WAIT_WIN: if (win_valid) begin
                state_d = EXEC;
                pe_pindex_d = win_pindex;
                lat_d = LAT_W'(PE_LAT);
            end
            // a zero count means pe_out now reflects the window captured at pe_en
            EXEC: if (lat_q == '0) begin
                state_d = EMIT;
                out_data_d = pe_out;
                out_k_d = k;
                out_row_d = r;
                out_col_d = c;
            end else begin
                lat_d = lat_q - 1'b1;
            end
            EMIT: if (out_ready) begin
                cnt_inc = 1'b1;
                state_d = last ? FIN : (wrap_c && wrap_r) ? LOAD_W : REQ_WIN;
            end
            FIN: begin
                state_d = IDLE;
                busy_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            pe_pindex_q <= '0;
            lat_q <= '0;
            out_data_q <= '0;
            out_k_q <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q <= busy_d;
            pe_pindex_q <= pe_pindex_d;
            lat_q <= lat_d;
            out_data_q <= out_data_d;
            out_k_q <= out_k_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    assign busy = busy_q;
    assign done = state_q == FIN;
    assign wgt_req = state_q == LOAD_W;
    assign wgt_k = k;
    assign win_req = state_q == REQ_WIN;
    assign win_row = r;
    assign win_col = c;
    assign pe_pindex = pe_pindex_q;
    assign pe_en = (state_q == WAIT_WIN) && win_valid;
    assign out_valid = state_q == EMIT;
    assign out_data = out_data_q;
    assign out_k = out_k_q;
    assign out_row = out_row_q;
    assign out_col = out_col_q;
endmodule

// File: tb/tb_pe_dc_sched.sv
// tb_pe_dc_sched: randomized bench for pe_dc_sched on 2x2 positions x 2 kernels at PE_LAT 1, 0 and 3
module tb_pe_dc_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic wgt_valid = 1'b0;
    logic win_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [1:0] win_pindex = '0;
    logic [3:0] pe_out = '0;
    logic [1:0] sel = '0;
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    logic busy_a[3], done_a[3], wgt_req_a[3], win_req_a[3], pe_en_a[3], out_valid_a[3];
    logic wgt_k_a[3], win_row_a[3], win_col_a[3], out_k_a[3], out_row_a[3], out_col_a[3];
    logic [1:0] pe_pindex_a[3];
    logic [3:0] out_data_a[3];
    logic busy, done, wgt_req, win_req, pe_en, out_valid, wgt_k, win_row, win_col, out_k, out_row, out_col;
    logic [1:0] pe_pindex;
    logic [3:0] out_data;
    logic [17:0] all_out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pe_dc_sched #(
            .OH(2), .OW(2), .N_KERNEL(2), .POOL_H(2), .POOL_W(2), .PE_LAT(g == 0 ? 1 : g == 1 ? 0 : 3)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start && (sel == 2'(g))), .busy(busy_a[g]), .done(done_a[g]),
            .wgt_req(wgt_req_a[g]), .wgt_k(wgt_k_a[g]), .wgt_valid(wgt_valid),
            .win_req(win_req_a[g]), .win_row(win_row_a[g]), .win_col(win_col_a[g]),
            .win_valid(win_valid), .win_pindex(win_pindex), .pe_pindex(pe_pindex_a[g]),
            .pe_en(pe_en_a[g]), .pe_out(pe_out), .out_valid(out_valid_a[g]), .out_ready(out_ready),
            .out_data(out_data_a[g]), .out_k(out_k_a[g]), .out_row(out_row_a[g]), .out_col(out_col_a[g])
        );
    end

    always_comb begin
        busy = busy_a[sel];
        done = done_a[sel];
        wgt_req = wgt_req_a[sel];
        wgt_k = wgt_k_a[sel];
        win_req = win_req_a[sel];
        win_row = win_row_a[sel];
        win_col = win_col_a[sel];
        pe_pindex = pe_pindex_a[sel];
        pe_en = pe_en_a[sel];
        out_valid = out_valid_a[sel];
        out_data = out_data_a[sel];
        out_k = out_k_a[sel];
        out_row = out_row_a[sel];
        out_col = out_col_a[sel];
        all_out = {busy, done, wgt_req, wgt_k, win_req, win_row, win_col, pe_pindex, pe_en,
                   out_valid, out_data, out_k, out_row, out_col};
    end

    // observations of the last pass; expected results come from the position order and the pe_out history
    logic [3:0] pe_hist[int];
    logic [6:0] hs_got[$], hs_exp[$];
    int hs_cyc[$];
    int n_hs, n_en, n_wgt, n_win, n_stall, done_cnt, done_cyc;
    int pidx_bad, stab_bad, winv_bad, busy_bad, wgtk_bad, winrc_bad;
    bit timeout, post_busy;
    logic [17:0] abort_out;

    function automatic int lat_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 0 : 3;
    endfunction

    task automatic run_pass(input int stall_pos, input int stall_len, input int abort_pos, input bit spur, input bit rnd);
        int en_q[$];
        int wcnt = -1, stall_left = stall_len, lat = lat_of(sel), abort_ph = 0, t;
        bit win_due = 0, holding = 0, have_pidx = 0, fin = 0;
        logic [1:0] pidx_exp = '0;
        logic [6:0] hold = '0;
        logic [3:0] exp_d;
        hs_got.delete(); hs_exp.delete(); hs_cyc.delete();
        {n_hs, n_en, n_wgt, n_win, n_stall, done_cnt} = '0;
        {pidx_bad, stab_bad, winv_bad, busy_bad, wgtk_bad, winrc_bad} = '0;
        done_cyc = -1;
        timeout = 0;
        abort_out = 'x;
        for (int i = 0; i < 3000 && !fin; i++) begin
            @(posedge clk); #1;
            start = (i == 0) || done || (rnd && abort_ph == 0 && $urandom_range(0, 7) == 0);
            rst = abort_ph == 1;
            pe_out = 4'($urandom);
            pe_hist[cyc] = pe_out;
            win_pindex = 2'($urandom);
            wgt_valid = wcnt == 0;
            if (wcnt >= 0) wcnt--;
            win_valid = win_due || (spur && out_valid && $urandom_range(0, 1) == 1);
            win_due = 0;
            if (out_valid && n_hs == stall_pos && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                n_stall++;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(negedge clk);
            if (abort_ph == 2) begin
                abort_out = all_out;
                fin = 1;
            end else begin
                if (abort_ph == 1) abort_ph = 2;
                if ((i == 0) == busy) busy_bad++;
                if (have_pidx && pe_pindex !== pidx_exp) pidx_bad++;
                if (pe_en) begin
                    en_q.push_back(cyc);
                    pidx_exp = win_pindex;
                    have_pidx = 1;
                    if (n_en == abort_pos) abort_ph = 1;
                    n_en++;
                end
                if (wgt_req) begin
                    if (wgt_k !== 1'(n_wgt)) wgtk_bad++;
                    n_wgt++;
                    wcnt = $urandom_range(0, 2);
                end
                if (win_req) begin
                    if (win_row !== 1'((n_win / 2) % 2) || win_col !== 1'(n_win % 2)) winrc_bad++;
                    if (out_valid) winv_bad++;
                    win_due = 1;
                    n_win++;
                end
                if (out_valid) begin
                    if (holding && {out_k, out_row, out_col, out_data} !== hold) stab_bad++;
                    hold = {out_k, out_row, out_col, out_data};
                    holding = 1;
                    if (out_ready) begin
                        holding = 0;
                        exp_d = 4'bx;
                        if (en_q.size() > 0) begin
                            t = en_q.pop_front();
                            exp_d = pe_hist[t + lat + 1];
                        end
                        hs_got.push_back(hold);
                        hs_exp.push_back({1'(n_hs / 4), 1'((n_hs / 2) % 2), 1'(n_hs % 2), exp_d});
                        hs_cyc.push_back(cyc);
                        n_hs++;
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    fin = 1;
                end
            end
        end
        timeout = !fin;
        @(posedge clk); #1;
        {start, rst, wgt_valid, win_valid} = '0;
        @(negedge clk);
        post_busy = busy || wgt_req;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            {start, wgt_valid, win_valid, out_ready} = 4'($urandom);
            pe_out = 4'($urandom);
            win_pindex = 2'($urandom);
            @(negedge clk);
            n_vec++;
            if (all_out !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", i, all_out);
            end
        end
        @(posedge clk); #1;
        {rst, start, wgt_valid, win_valid} = '0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || wgt_req !== 1'b0) begin
            n_bad++;
            $display("FAIL start_in_reset: busy=%b wgt_req=%b want 0 0", busy, wgt_req);
        end
    endtask

    task automatic test_full_pass();
        sel = 2'd0;
        run_pass(-1, 0, -1, 0, 0);
        n_vec++;
        if (timeout || n_hs != 8) begin
            n_bad++;
            $display("FAIL pass_count: got %0d results timeout=%0d want 8", n_hs, timeout);
        end
        for (int i = 0; i < n_hs; i++) begin
            n_vec++;
            if (hs_got[i] !== hs_exp[i]) begin
                n_bad++;
                $display("FAIL pass_result[%0d]: got %h want %h", i, hs_got[i], hs_exp[i]);
            end
        end
        for (int i = 1; i < n_hs; i++) if (i % 4 != 0) begin
            n_vec++;
            if (hs_cyc[i] - hs_cyc[i-1] != 5) begin
                n_bad++;
                $display("FAIL pass_spacing[%0d]: got %0d cycles want 5", i, hs_cyc[i] - hs_cyc[i-1]);
            end
        end
        n_vec++;
        if (n_wgt != 2 || wgtk_bad != 0) begin
            n_bad++;
            $display("FAIL pass_wgt_req: got %0d reqs %0d bad k want 2 0", n_wgt, wgtk_bad);
        end
        n_vec++;
        if (done_cnt != 1 || n_hs != 8 || done_cyc != hs_cyc[n_hs-1] + 1) begin
            n_bad++;
            $display("FAIL pass_done: got %0d pulses at cycle %0d want 1 right after last handshake", done_cnt, done_cyc);
        end
        n_vec++;
        if (busy_bad != 0 || post_busy || winrc_bad != 0 || pidx_bad != 0) begin
            n_bad++;
            $display("FAIL pass_control: busy_bad=%0d post_busy=%0d winrc_bad=%0d pidx_bad=%0d want 0", busy_bad, post_busy, winrc_bad, pidx_bad);
        end
    endtask

    task automatic test_backpressure();
        sel = 2'd0;
        run_pass(2, 10, -1, 0, 0);
        n_vec++;
        if (timeout || n_hs != 8 || n_stall != 10) begin
            n_bad++;
            $display("FAIL bp_count: got %0d results %0d stalled cycles want 8 10", n_hs, n_stall);
        end
        for (int i = 0; i < n_hs; i++) begin
            n_vec++;
            if (hs_got[i] !== hs_exp[i]) begin
                n_bad++;
                $display("FAIL bp_result[%0d]: got %h want %h", i, hs_got[i], hs_exp[i]);
            end
        end
        n_vec++;
        if (stab_bad != 0 || winv_bad != 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable cycles %0d win_req during valid want 0 0", stab_bad, winv_bad);
        end
        n_vec++;
        if (n_hs != 8 || hs_cyc[2] - hs_cyc[1] != 15) begin
            n_bad++;
            $display("FAIL bp_resume: got %0d results, spacing %0d want 15", n_hs, n_hs == 8 ? hs_cyc[2] - hs_cyc[1] : -1);
        end
    endtask

    task automatic test_latency_sweep();
        for (int s = 1; s < 3; s++) begin
            sel = 2'(s);
            run_pass(-1, 0, -1, 0, 0);
            n_vec++;
            if (timeout || n_hs != 8 || done_cnt != 1) begin
                n_bad++;
                $display("FAIL lat%0d_count: got %0d results %0d done want 8 1", lat_of(sel), n_hs, done_cnt);
            end
            for (int i = 0; i < n_hs; i++) begin
                n_vec++;
                if (hs_got[i] !== hs_exp[i]) begin
                    n_bad++;
                    $display("FAIL lat%0d_result[%0d]: got %h want %h", lat_of(sel), i, hs_got[i], hs_exp[i]);
                end
            end
            for (int i = 1; i < n_hs; i++) if (i % 4 != 0) begin
                n_vec++;
                if (hs_cyc[i] - hs_cyc[i-1] != lat_of(sel) + 4) begin
                    n_bad++;
                    $display("FAIL lat%0d_spacing[%0d]: got %0d want %0d", lat_of(sel), i, hs_cyc[i] - hs_cyc[i-1], lat_of(sel) + 4);
                end
            end
        end
    endtask

    task automatic test_pindex();
        sel = 2'd0;
        run_pass(-1, 0, -1, 1, 0);
        n_vec++;
        if (timeout || n_en != 8 || n_hs != 8) begin
            n_bad++;
            $display("FAIL pidx_en: got %0d pe_en %0d results want 8 8", n_en, n_hs);
        end
        n_vec++;
        if (pidx_bad != 0) begin
            n_bad++;
            $display("FAIL pidx_hold: got %0d cycles with wrong pe_pindex want 0", pidx_bad);
        end
        for (int i = 0; i < n_hs; i++) begin
            n_vec++;
            if (hs_got[i] !== hs_exp[i]) begin
                n_bad++;
                $display("FAIL pidx_result[%0d]: got %h want %h", i, hs_got[i], hs_exp[i]);
            end
        end
    endtask

    task automatic test_abort();
        sel = 2'd0;
        run_pass(-1, 0, 5, 0, 0);
        n_vec++;
        if (abort_out !== '0 || done_cnt != 0 || n_hs != 5 || post_busy) begin
            n_bad++;
            $display("FAIL abort: got outputs %h, %0d done, %0d results want 0, 0, 5", abort_out, done_cnt, n_hs);
        end
        run_pass(-1, 0, -1, 0, 0);
        n_vec++;
        if (timeout || n_hs != 8 || done_cnt != 1 || n_wgt != 2) begin
            n_bad++;
            $display("FAIL restart_count: got %0d results %0d done %0d wgt_req want 8 1 2", n_hs, done_cnt, n_wgt);
        end
        for (int i = 0; i < n_hs; i++) begin
            n_vec++;
            if (hs_got[i] !== hs_exp[i]) begin
                n_bad++;
                $display("FAIL restart_result[%0d]: got %h want %h", i, hs_got[i], hs_exp[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            sel = 2'($urandom_range(0, 2));
            run_pass(-1, 0, -1, 1, 1);
            n_vec++;
            if (timeout || n_hs != 8 || done_cnt != 1 || n_en != 8) begin
                n_bad++;
                $display("FAIL rand%0d_count: got %0d results %0d done %0d pe_en want 8 1 8", n, n_hs, done_cnt, n_en);
            end
            n_vec++;
            if (stab_bad != 0 || winv_bad != 0 || pidx_bad != 0 || busy_bad != 0 || wgtk_bad != 0 || winrc_bad != 0) begin
                n_bad++;
                $display("FAIL rand%0d_control: stab=%0d winv=%0d pidx=%0d busy=%0d wgtk=%0d winrc=%0d want all 0", n, stab_bad, winv_bad, pidx_bad, busy_bad, wgtk_bad, winrc_bad);
            end
            for (int i = 0; i < n_hs; i++) begin
                n_vec++;
                if (hs_got[i] !== hs_exp[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d_result[%0d]: got %h want %h", n, i, hs_got[i], hs_exp[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_backpressure();
        test_latency_sweep();
        test_pindex();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
